rr_response_router: RTL

- Return path of the round-robin PLM scheduler.
- The scheduling kernel issues consumer requests to bank ports (NBANKS*NPORTS kernels). This block tracks which consumer owns each issued slot and waits out the PLM read latency.
- It then routes read data, or a write acknowledge, back to the owning consumer as a one-cycle response.
- It also keeps per-consumer outstanding-request counters and flags routing collisions.

---
 rtl/rr_response_router.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rr_response_router.sv
// Return path of the round-robin PLM scheduler: tracks the owner of each
// issued kernel slot, waits out the PLM read latency and routes the read
// data or write acknowledge back to that consumer as a one-cycle response.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   grant_valid    per-kernel issue strobe
//   grant_consumer per-kernel owning consumer index
//   grant_wr       per-kernel "issue was a write"
//   plm_outputs    per-kernel PLM read data
//   responses      per-consumer {value, wr_ack, valid}, registered pulse
//   outstanding    per-consumer issued-but-unanswered count
//   collision_err  sticky flag: two kernels hit one consumer in a cycle
module rr_response_router #(
  parameter int NCONSUMERS       = 8,
  parameter int NBANKS           = 4,
  parameter int NPORTS           = 2,
  parameter int VALUE_WIDTH      = 8,
  parameter int PLM_READ_LATENCY = 1,
  localparam int NKERNELS   = NBANKS * NPORTS,
  localparam int CID_W      = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1,
  localparam int RESP_WIDTH = VALUE_WIDTH + 2,
  localparam int OUT_W      =
    $clog2(NKERNELS * (PLM_READ_LATENCY + 1) + 1)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NKERNELS-1:0]                    grant_valid,
  input  logic [NKERNELS-1:0][CID_W-1:0]         grant_consumer,
  input  logic [NKERNELS-1:0]                    grant_wr,
  input  logic [NKERNELS-1:0][VALUE_WIDTH-1:0]   plm_outputs,
  output logic [NCONSUMERS-1:0][RESP_WIDTH-1:0]  responses,
  output logic [NCONSUMERS-1:0][OUT_W-1:0]       outstanding,
  output logic                                   collision_err
);

  // Stage 0 registers the grant in step with the PLM's own input register,
  // so the head lines up with read data PLM_READ_LATENCY cycles later.
  localparam int DEPTH   = PLM_READ_LATENCY + 1;
  localparam int CNT_MAX = (1 << OUT_W) - 1;

  typedef struct packed {
    logic             vld;
    logic [CID_W-1:0] cid;
    logic             wr;
  } tag_t;

  tag_t tag_q [NKERNELS][DEPTH];
  tag_t cap_d [NKERNELS];
  tag_t head  [NKERNELS];

  logic [NCONSUMERS-1:0][RESP_WIDTH-1:0] resp_q, resp_d;
  logic [NCONSUMERS-1:0][OUT_W-1:0]      cnt_q, cnt_d;
  logic [NCONSUMERS-1:0]                 clash_v;
  logic                                  err_q, err_d;

  // Out-of-range owners are dropped here, so they never count or respond.
  always_comb begin
    for (int k = 0; k < NKERNELS; k++) begin
      cap_d[k].vld = grant_valid[k] &&
                     (int'(grant_consumer[k]) < NCONSUMERS);
      cap_d[k].cid = grant_consumer[k];
      cap_d[k].wr  = grant_wr[k];
      head[k]      = tag_q[k][DEPTH-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NKERNELS; k++) begin
        for (int s = 0; s < DEPTH; s++) begin
          tag_q[k][s] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < NKERNELS; k++) begin
        tag_q[k][0] <= cap_d[k];
        for (int s = 1; s < DEPTH; s++) begin
          tag_q[k][s] <= tag_q[k][s-1];
        end
      end
    end
  end

  for (genvar c = 0; c < NCONSUMERS; c++) begin : g_cons
    logic [RESP_WIDTH-1:0] rsp;
    logic [OUT_W-1:0]      cnt;
    logic                  hit;
    logic                  clash;
    int                    net;

    // Lowest kernel index wins; later hits only raise the clash flag
    // but still retire from the outstanding count.
    always_comb begin
      rsp   = '0;
      hit   = 1'b0;
      clash = 1'b0;
      net   = int'(cnt_q[c]);
      for (int k = 0; k < NKERNELS; k++) begin
        if (cap_d[k].vld && cap_d[k].cid == CID_W'(c)) begin
          net = net + 1;
        end
        if (head[k].vld && head[k].cid == CID_W'(c)) begin
          net = net - 1;
          if (hit) begin
            clash = 1'b1;
          end else begin
            hit = 1'b1;
            if (head[k].wr) begin
              rsp = {{VALUE_WIDTH{1'b0}}, 2'b11};
            end else begin
              rsp = {plm_outputs[k], 2'b01};
            end
          end
        end
      end
      if (net < 0) begin
        cnt = '0;
      end else if (net > CNT_MAX) begin
        cnt = OUT_W'(CNT_MAX);
      end else begin
        cnt = OUT_W'(net);
      end
    end

    assign resp_d[c]  = rsp;
    assign cnt_d[c]   = cnt;
    assign clash_v[c] = clash;
  end

  assign err_d = err_q | (|clash_v);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      resp_q <= resp_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign responses     = resp_q;
  assign outstanding   = cnt_q;
  assign collision_err = err_q;

endmodule
